// File: rtl/rc_pkg.sv
// Shared types and default timing constants for the RC receiver input path.
// Defaults assume a 1 us sample tick.
package rc_pkg;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } ppm_state_t;

   localparam int DEF_NCH      = 8;
   localparam int DEF_MIN_INT  = 500;
   localparam int DEF_SYNC_MIN = 5000;
   localparam int DEF_TIMEOUT  = 50000;
   localparam int DEF_IDX_W    = $clog2(DEF_NCH + 1);

   // idx must be able to hold NCH itself, the "frame full" value.
   function automatic int idx_width(input int nch);
      return $clog2(nch + 1);
   endfunction

endpackage

// File: rtl/ppm_edge_sync.sv
// Synchroniser chain for the raw PPM line plus active-edge detection.
// edge_det is high for one cycle per synchronised transition matching POLARITY.
module ppm_edge_sync #(
   parameter int SYNC_STAGES = 3,
   parameter bit POLARITY    = 1'b1
) (
   input  logic CLK,
   input  logic RST,
   input  logic PPM,
   output logic edge_det
);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   prev_reg;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync_reg <= '0;
         prev_reg <= 1'b0;
      end else begin
         sync_reg <= {sync_reg[SYNC_STAGES-2:0], PPM};
         prev_reg <= sync_reg[SYNC_STAGES-1];
      end
   end

   generate
      if (POLARITY) begin : g_rise
         assign edge_det = sync_reg[SYNC_STAGES-1] & ~prev_reg;
      end else begin : g_fall
         assign edge_det = ~sync_reg[SYNC_STAGES-1] & prev_reg;
      end
   endgenerate

endmodule

// File: rtl/ppm_frame_decoder.sv
// CPPM frame decoder: measures edge-to-edge intervals, assembles NCH channel
// codes in a shadow bank and publishes them atomically on a valid sync gap.
module ppm_frame_decoder
   import rc_pkg::*;
#(
   parameter int NCH         = DEF_NCH,
   parameter int CW          = 16,
   parameter int SYNC_STAGES = 3,
   parameter bit POLARITY    = 1'b1,
   parameter int MIN_INT     = DEF_MIN_INT,
   parameter int SYNC_MIN    = DEF_SYNC_MIN,
   parameter int TIMEOUT     = DEF_TIMEOUT
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              PPM,
   output logic [NCH*CW-1:0] CH,
   output logic              FRAME_VALID,
   output logic              FRAME_ERR,
   output logic              LOST
);

   localparam int            IW      = idx_width(NCH);
   localparam logic [CW-1:0] MIN_I   = CW'(MIN_INT);
   localparam logic [CW-1:0] SYNC_I  = CW'(SYNC_MIN);
   localparam logic [CW-1:0] TMO_I   = CW'(TIMEOUT);
   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
   localparam logic [IW-1:0] NCH_I   = IW'(NCH);

   logic          edge_det;
   logic [CW-1:0] cnt_reg;
   ppm_state_t    state_reg, state_next;
   logic [IW-1:0] idx_reg, idx_next;
   logic          fv_reg, fv_next;
   logic          fe_reg, fe_next;
   logic          lost_reg, lost_next;
   logic          shadow_we;
   logic          ch_load;
   logic [CW-1:0] shadow_reg [NCH];
   logic [CW-1:0] ch_reg     [NCH];

   ppm_edge_sync #(
      .SYNC_STAGES (SYNC_STAGES),
      .POLARITY    (POLARITY)
   ) u_edge_sync (
      .CLK      (CLK),
      .RST      (RST),
      .PPM      (PPM),
      .edge_det (edge_det)
   );

   // cnt_reg holds the interval since the previous edge when edge_det is high.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_reg <= '0;
      end else if (edge_det) begin
         cnt_reg <= CW'(1);
      end else if (cnt_reg != CNT_MAX) begin
         cnt_reg <= cnt_reg + CW'(1);
      end
   end

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      fv_next    = 1'b0;
      fe_next    = 1'b0;
      lost_next  = lost_reg;
      shadow_we  = 1'b0;
      ch_load    = 1'b0;
      if (edge_det) begin
         case (state_reg)
            HUNT: begin
               if (cnt_reg >= SYNC_I) begin
                  state_next = LOCKED;
                  idx_next   = '0;
               end
            end
            LOCKED: begin
               if (cnt_reg < MIN_I) begin
                  fe_next    = 1'b1;
                  state_next = HUNT;
                  idx_next   = '0;
               end else if (cnt_reg < SYNC_I) begin
                  if (idx_reg == NCH_I) begin
                     fe_next    = 1'b1;
                     state_next = HUNT;
                     idx_next   = '0;
                  end else begin
                     shadow_we = 1'b1;
                     idx_next  = idx_reg + IW'(1);
                  end
               end else begin
                  // Any sync gap re-anchors the frame, complete or not.
                  idx_next = '0;
                  if (idx_reg == NCH_I) begin
                     ch_load   = 1'b1;
                     fv_next   = 1'b1;
                     lost_next = 1'b0;
                  end else begin
                     fe_next = 1'b1;
                  end
               end
            end
            default: begin
               state_next = HUNT;
               idx_next   = '0;
            end
         endcase
      end else if (cnt_reg == TMO_I) begin
         lost_next  = 1'b1;
         state_next = HUNT;
         idx_next   = '0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg <= HUNT;
         idx_reg   <= '0;
         fv_reg    <= 1'b0;
         fe_reg    <= 1'b0;
         lost_reg  <= 1'b1;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         fv_reg    <= fv_next;
         fe_reg    <= fe_next;
         lost_reg  <= lost_next;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < NCH; i++) begin
            shadow_reg[i] <= '0;
            ch_reg[i]     <= '0;
         end
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (shadow_we && idx_reg == IW'(i)) begin
               shadow_reg[i] <= cnt_reg;
            end
            if (ch_load) begin
               ch_reg[i] <= shadow_reg[i];
            end
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_ch
         assign CH[gi*CW +: CW] = ch_reg[gi];
      end
   endgenerate

   assign FRAME_VALID = fv_reg;
   assign FRAME_ERR   = fe_reg;
   assign LOST        = lost_reg;

endmodule
